// File: rtl/alu.sv
// 8-bit, 16-function ALU with a registered 16-bit result.
// The result drives a shared bus that is released to high-Z when oe is low.
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  a_in,
   input  logic [7:0]  b_in,
   input  logic [3:0]  command_in,
   input  logic        oe,
   output logic [15:0] d_out
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_INC  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_DEC  = 4'b0011;
   localparam logic [3:0] OP_MUL  = 4'b0100;
   localparam logic [3:0] OP_DIV  = 4'b0101;
   localparam logic [3:0] OP_SHL  = 4'b0110;
   localparam logic [3:0] OP_SHR  = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_INV  = 4'b1010;
   localparam logic [3:0] OP_NAND = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_XOR  = 4'b1101;
   localparam logic [3:0] OP_XNOR = 4'b1110;
   localparam logic [3:0] OP_BUF  = 4'b1111;

   // Quotient with a saturated all-ones answer for a zero divisor.
   function automatic logic [15:0] safe_div(input logic [7:0] num, input logic [7:0] den);
      logic [15:0] q;
      if (den == 8'h00) begin
         q = 16'hFFFF;
      end else begin
         q = {8'h00, num / den};
      end
      return q;
   endfunction

   logic [15:0] a_ext_s;
   logic [15:0] b_ext_s;
   logic [15:0] mul_s;
   logic [15:0] next_result_s;
   logic [15:0] result_r;

   assign a_ext_s = {8'h00, a_in};
   assign b_ext_s = {8'h00, b_in};
   // Only the low nibbles take part in the multiply.
   assign mul_s   = {12'h000, a_in[3:0]} * {12'h000, b_in[3:0]};

   // Opcode decode; unknown or unlisted opcodes fall to a zero result.
   always_comb begin
      next_result_s = 16'h0000;
      case (command_in)
         OP_ADD:  next_result_s = a_ext_s + b_ext_s;
         OP_INC:  next_result_s = a_ext_s + 16'h0001;
         OP_SUB:  next_result_s = a_ext_s - b_ext_s;
         OP_DEC:  next_result_s = a_ext_s - 16'h0001;
         OP_MUL:  next_result_s = mul_s;
         OP_DIV:  next_result_s = safe_div(a_in, b_in);
         OP_SHL:  next_result_s = {7'b000_0000, a_in, 1'b0};
         OP_SHR:  next_result_s = {8'h00, 1'b0, a_in[7:1]};
         OP_AND:  next_result_s = {8'h00, a_in & b_in};
         OP_OR:   next_result_s = {8'h00, a_in | b_in};
         OP_INV:  next_result_s = {8'h00, ~a_in};
         OP_NAND: next_result_s = {8'h00, ~(a_in & b_in)};
         OP_NOR:  next_result_s = {8'h00, ~(a_in | b_in)};
         OP_XOR:  next_result_s = {8'h00, a_in ^ b_in};
         OP_XNOR: next_result_s = {8'h00, ~(a_in ^ b_in)};
         OP_BUF:  next_result_s = {8'h00, a_in};
         default: next_result_s = 16'h0000;
      endcase
   end

   // Result register; keeps updating regardless of oe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r <= 16'h0000;
      end else begin
         result_r <= next_result_s;
      end
   end

   assign d_out = oe ? result_r : 16'hzzzz;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: hand-computed expectations, bus sharing via a
// bench-side driver that owns the bus whenever the ALU output is disabled.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [7:0]  a_in;
   logic [7:0]  b_in;
   logic [3:0]  command_in;
   logic        oe;
   wire  [15:0] bus;
   logic        tb_drv;
   logic [15:0] tb_val;

   int n_cmp;
   int n_err;

   assign bus = tb_drv ? tb_val : 16'hzzzz;

   alu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_in       (a_in),
      .b_in       (b_in),
      .command_in (command_in),
      .oe         (oe),
      .d_out      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Drive one operation at the falling edge, sample just after the next rising edge.
   task automatic run_op(input string tag, input logic [3:0] cmd, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp);
      @(negedge clk);
      command_in = cmd;
      a_in       = a;
      b_in       = b;
      @(posedge clk);
      #1;
      check_eq(tag, bus, exp);
   endtask

   typedef struct {
      logic [3:0]  cmd;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      tb_drv     = 1'b0;
      tb_val     = 16'h0000;
      oe         = 1'b1;
      a_in       = 8'h00;
      b_in       = 8'h00;
      command_in = 4'b1111;
      rst_n      = 1'b0;

      // a=3, b=5 across all opcodes
      vecs.push_back('{4'h0, 8'h03, 8'h05, 16'h0008});
      vecs.push_back('{4'h1, 8'h03, 8'h05, 16'h0004});
      vecs.push_back('{4'h2, 8'h03, 8'h05, 16'hFFFE});
      vecs.push_back('{4'h3, 8'h03, 8'h05, 16'h0002});
      vecs.push_back('{4'h4, 8'h03, 8'h05, 16'h000F});
      vecs.push_back('{4'h5, 8'h03, 8'h05, 16'h0000});
      vecs.push_back('{4'h6, 8'h03, 8'h05, 16'h0006});
      vecs.push_back('{4'h7, 8'h03, 8'h05, 16'h0001});
      vecs.push_back('{4'h8, 8'h03, 8'h05, 16'h0001});
      vecs.push_back('{4'h9, 8'h03, 8'h05, 16'h0007});
      vecs.push_back('{4'hA, 8'h03, 8'h05, 16'h00FC});
      vecs.push_back('{4'hB, 8'h03, 8'h05, 16'h00FE});
      vecs.push_back('{4'hC, 8'h03, 8'h05, 16'h00F8});
      vecs.push_back('{4'hD, 8'h03, 8'h05, 16'h0006});
      vecs.push_back('{4'hE, 8'h03, 8'h05, 16'h00F9});
      vecs.push_back('{4'hF, 8'h03, 8'h05, 16'h0003});
      // a=C9, b=35 exercises the upper operand nibbles
      vecs.push_back('{4'h0, 8'hC9, 8'h35, 16'h00FE});
      vecs.push_back('{4'h1, 8'hC9, 8'h35, 16'h00CA});
      vecs.push_back('{4'h2, 8'hC9, 8'h35, 16'h0094});
      vecs.push_back('{4'h3, 8'hC9, 8'h35, 16'h00C8});
      vecs.push_back('{4'h4, 8'hC9, 8'h35, 16'h002D});
      vecs.push_back('{4'h5, 8'hC9, 8'h35, 16'h0003});
      vecs.push_back('{4'h6, 8'hC9, 8'h35, 16'h0192});
      vecs.push_back('{4'h7, 8'hC9, 8'h35, 16'h0064});
      vecs.push_back('{4'h8, 8'hC9, 8'h35, 16'h0001});
      vecs.push_back('{4'h9, 8'hC9, 8'h35, 16'h00FD});
      vecs.push_back('{4'hA, 8'hC9, 8'h35, 16'h0036});
      vecs.push_back('{4'hB, 8'hC9, 8'h35, 16'h00FE});
      vecs.push_back('{4'hC, 8'hC9, 8'h35, 16'h0002});
      vecs.push_back('{4'hD, 8'hC9, 8'h35, 16'h00FC});
      vecs.push_back('{4'hE, 8'hC9, 8'h35, 16'h0003});
      vecs.push_back('{4'hF, 8'hC9, 8'h35, 16'h00C9});
      // boundaries
      vecs.push_back('{4'h1, 8'hFF, 8'h00, 16'h0100});
      vecs.push_back('{4'h3, 8'h00, 8'h00, 16'hFFFF});
      vecs.push_back('{4'h0, 8'hFF, 8'hFF, 16'h01FE});
      vecs.push_back('{4'h6, 8'h81, 8'h00, 16'h0102});
      vecs.push_back('{4'h4, 8'hF3, 8'h24, 16'h000C});
      vecs.push_back('{4'h4, 8'hFF, 8'hFF, 16'h00E1});
      vecs.push_back('{4'h5, 8'h07, 8'h00, 16'hFFFF});
      vecs.push_back('{4'h5, 8'hFF, 8'h01, 16'h00FF});
      vecs.push_back('{4'h2, 8'h01, 8'h02, 16'hFFFF});

      // Reset state before any clock edge
      #1;
      check_eq("reset_oe1", bus, 16'h0000);
      oe     = 1'b0;
      tb_val = 16'hA5A5;
      tb_drv = 1'b1;
      #1;
      check_eq("reset_oe0_bus_free", bus, 16'hA5A5);
      tb_drv = 1'b0;
      oe     = 1'b1;
      #1;
      check_eq("reset_oe1_again", bus, 16'h0000);

      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d_op%h", i, vecs[i].cmd), vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Output enable gating: register keeps loading while the bus is released
      @(negedge clk);
      oe     = 1'b0;
      tb_val = 16'h5A5A;
      tb_drv = 1'b1;
      command_in = 4'h0;
      a_in       = 8'd20;
      b_in       = 8'd10;
      @(posedge clk);
      #1;
      check_eq("oe0_bus_free", bus, 16'h5A5A);
      tb_drv = 1'b0;
      oe     = 1'b1;
      #1;
      check_eq("oe1_no_edge", bus, 16'h001E);
      run_op("oe1_add_25_17", 4'h0, 8'd25, 8'd17, 16'h002A);

      // Latency: change between edges, output holds until the next rising edge
      @(negedge clk);
      command_in = 4'h2;
      #2;
      check_eq("hold_before_edge", bus, 16'h002A);
      @(posedge clk);
      #1;
      check_eq("update_after_edge", bus, 16'h0008);
      @(posedge clk);
      #1;
      check_eq("stable_next_edge", bus, 16'h0008);

      // Asynchronous reset mid-run
      run_op("mul_15_15", 4'h4, 8'd15, 8'd15, 16'h00E1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("async_reset_drop", bus, 16'h0000);
      @(posedge clk);
      #1;
      check_eq("reset_held_edge", bus, 16'h0000);
      @(negedge clk);
      rst_n      = 1'b1;
      command_in = 4'h0;
      a_in       = 8'd1;
      b_in       = 8'd2;
      @(posedge clk);
      #1;
      check_eq("first_post_reset", bus, 16'h0003);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
